// File: rtl/bcd_c_pkg.sv
// Shared constants for the bcd_c display path: digit segment patterns
// (active-low, {dp,g,f,e,d,c,b,a}) and the saturation limit.
package bcd_c_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [9:0] SAT_LIMIT = 10'd999;

endpackage

// File: rtl/seg7_digit_enc.sv
// One BCD nibble to a seven-segment pattern; non-decimal nibbles go dark.
// SEG_ACTIVE_LOW=0 inverts every pattern for common-cathode displays.
module seg7_digit_enc
    import bcd_c_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_bcd,
    output logic [7:0] o_seg
);

    logic [7:0] w_pat;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_pat = SEG_BLANK;
        case (i_bcd)
            4'd0:    w_pat = SEG_0;
            4'd1:    w_pat = SEG_1;
            4'd2:    w_pat = SEG_2;
            4'd3:    w_pat = SEG_3;
            4'd4:    w_pat = SEG_4;
            4'd5:    w_pat = SEG_5;
            4'd6:    w_pat = SEG_6;
            4'd7:    w_pat = SEG_7;
            4'd8:    w_pat = SEG_8;
            4'd9:    w_pat = SEG_9;
            default: w_pat = SEG_BLANK;
        endcase
        o_seg = SEG_ACTIVE_LOW ? w_pat : ~w_pat;
    end

endmodule

// File: rtl/bcd_c.sv
// 10-bit binary to three seven-segment digits, saturating at 999.
// Stage 1 registers double-dabble BCD plus blank flag; stage 2 registers patterns.
module bcd_c
    import bcd_c_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] in,
    input  logic       nothing,
    output logic [7:0] num2,
    output logic [7:0] num1,
    output logic [7:0] num0
);

    localparam logic [7:0] BLANK_PAT = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    // Shift-add-3: before each shift, any BCD nibble >= 5 gets 3 added.
    function automatic logic [11:0] bin_to_bcd(input logic [9:0] bin);
        logic [21:0] scratch;
        scratch = {12'd0, bin};
        for (int i = 0; i < 10; i++) begin
            if (scratch[13:10] >= 4'd5) scratch[13:10] = scratch[13:10] + 4'd3;
            if (scratch[17:14] >= 4'd5) scratch[17:14] = scratch[17:14] + 4'd3;
            if (scratch[21:18] >= 4'd5) scratch[21:18] = scratch[21:18] + 4'd3;
            scratch = scratch << 1;
        end
        return scratch[21:10];
    endfunction

    logic [9:0]  w_sat;
    logic [11:0] w_bcd;
    logic [11:0] r_bcd;
    logic        r_blank;
    logic [7:0]  w_seg2;
    logic [7:0]  w_seg1;
    logic [7:0]  w_seg0;

    assign w_sat = (in > SAT_LIMIT) ? SAT_LIMIT : in;
    assign w_bcd = bin_to_bcd(w_sat);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd   <= '0;
            r_blank <= 1'b1;
        end else begin
            r_bcd   <= w_bcd;
            r_blank <= nothing;
        end
    end

    seg7_digit_enc #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc2 (.i_bcd(r_bcd[11:8]), .o_seg(w_seg2));
    seg7_digit_enc #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc1 (.i_bcd(r_bcd[7:4]),  .o_seg(w_seg1));
    seg7_digit_enc #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc0 (.i_bcd(r_bcd[3:0]),  .o_seg(w_seg0));

    // Output registers reset to dark so the display is blank the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num2 <= BLANK_PAT;
            num1 <= BLANK_PAT;
            num0 <= BLANK_PAT;
        end else begin
            num2 <= r_blank ? BLANK_PAT : w_seg2;
            num1 <= r_blank ? BLANK_PAT : w_seg1;
            num0 <= r_blank ? BLANK_PAT : w_seg0;
        end
    end

endmodule

// File: tb/tb_bcd_c.sv
// Self-checking bench for bcd_c: vector table, full sweep, random pipelined
// stream against an arithmetic model, and reset/blank/throughput sequences.
module tb_bcd_c;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] in = '0;
    logic       nothing = 1'b0;
    logic [7:0] num2, num1, num0;
    logic [7:0] num2_h, num1_h, num0_h;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    typedef struct {
        logic [9:0]  v_in;
        logic        v_nothing;
        logic [23:0] v_exp;
    } vec_t;

    vec_t vecs [12];
    logic [23:0] exp_q [$];

    bcd_c #(.SEG_ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in(in), .nothing(nothing),
        .num2(num2), .num1(num1), .num0(num0)
    );

    bcd_c #(.SEG_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .in(in), .nothing(nothing),
        .num2(num2_h), .num1(num1_h), .num0(num0_h)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by plain arithmetic, then pattern lookup.
    function automatic logic [23:0] model(input int v, input logic blank);
        int s;
        if (blank) return 24'hFFFFFF;
        s = (v > 999) ? 999 : v;
        return {pat[s / 100], pat[(s / 10) % 10], pat[s % 10]};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [23:0] exp);
        check(name, {num2, num1, num0}, exp);
        check({name, "_hi"}, {num2_h, num1_h, num0_h}, ~exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{10'd0,    1'b0, 24'hC0C0C0};
        vecs[1]  = '{10'd7,    1'b0, 24'hC0C0F8};
        vecs[2]  = '{10'd999,  1'b0, 24'h909090};
        vecs[3]  = '{10'd1000, 1'b0, 24'h909090};
        vecs[4]  = '{10'd1023, 1'b0, 24'h909090};
        vecs[5]  = '{10'd123,  1'b0, 24'hF9A4B0};
        vecs[6]  = '{10'd456,  1'b0, 24'h999282};
        vecs[7]  = '{10'd58,   1'b0, 24'hC09280};
        vecs[8]  = '{10'd905,  1'b0, 24'h90C092};
        vecs[9]  = '{10'd500,  1'b1, 24'hFFFFFF};
        vecs[10] = '{10'd777,  1'b0, 24'hF8F8F8};
        vecs[11] = '{10'd100,  1'b0, 24'hF9C0C0};

        // Reset with in=123: dark during reset and after the first edge, then valid.
        in = 10'd123;
        #13;
        check_both("reset_hold", 24'hFFFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_both("reset_edge1", 24'hFFFFFF);
        step();
        check_both("reset_edge2", 24'hF9A4B0);

        for (int i = 0; i < 12; i++) begin
            in = vecs[i].v_in;
            nothing = vecs[i].v_nothing;
            step();
            step();
            check_both($sformatf("vec%0d_in%0d", i, vecs[i].v_in), vecs[i].v_exp);
        end
        nothing = 1'b0;

        for (int v = 0; v < 1024; v++) begin
            in = 10'(v);
            step();
            step();
            check_both($sformatf("sweep_%0d", v), model(v, 1'b0));
        end

        // Back-to-back values: 905 then 58, one per cycle.
        in = 10'd905;
        step();
        in = 10'd58;
        step();
        check_both("tput_905", 24'h90C092);
        step();
        check_both("tput_58", 24'hC09280);

        // One-cycle blank pulse on a stable 456.
        in = 10'd456;
        step();
        step();
        check_both("pulse_pre", 24'h999282);
        nothing = 1'b1;
        step();
        check_both("pulse_edge1", 24'h999282);
        nothing = 1'b0;
        step();
        check_both("pulse_dark", 24'hFFFFFF);
        step();
        check_both("pulse_after", 24'h999282);

        // Asynchronous reset pulse between edges with in=777.
        in = 10'd777;
        step();
        step();
        check_both("areset_pre", 24'hF8F8F8);
        #2;
        rst_n = 1'b0;
        #1;
        check_both("areset_immediate", 24'hFFFFFF);
        step();
        check_both("areset_held", 24'hFFFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_both("areset_edge1", 24'hFFFFFF);
        step();
        check_both("areset_edge2", 24'hF8F8F8);

        // Random stream at full throughput; output after each edge matches input two edges back.
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            int v;
            logic b;
            v = int'($urandom_range(0, 1023));
            b = ($urandom_range(0, 7) == 0);
            in = 10'(v);
            nothing = b;
            exp_q.push_back(model(v, b));
            step();
            if (exp_q.size() >= 2)
                check_both($sformatf("rand_%0d", c), exp_q[exp_q.size() - 2]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
